// File: rtl/mixer_lo_ctrl.sv
// mixer_lo_ctrl: sequencer for the LO-code mixer datapath.
//
// Takes interpolated samples over a valid/ready stream. Each sample leaves
// through a single registered output stage together with the 2-bit LO code
// that lines up with it. The LO follows a quarter-rate pattern:
//   I: +1, 0, -1, 0
//   Q:  0, +1, 0, -1
// The pattern steps once every (rate_div + 1) accepted samples.
//
// Start/stop sequencing: when en drops, the block does not stop at once.
// It keeps emitting live codes until it emits a zero code, so a -1/+1 lobe
// is never cut short at the mixer.
//
// Code encoding on lo: 00 = 0, 01 = +1, 10 = -1. The value 11 is never
// driven.

module mixer_lo_ctrl #(
    parameter int DIV_W  = 4,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              phase_sel,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] interp_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] interp_o,
    output logic [1:0]        lo,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] LO_ZERO = 2'b00;
    localparam logic [1:0] LO_POS  = 2'b01;
    localparam logic [1:0] LO_NEG  = 2'b10;

    // LO code for a given sequence select and phase index.
    //   I (sel=0) runs +1, 0, -1, 0.
    //   Q (sel=1) is the same pattern delayed by one phase.
    function automatic logic [1:0] seq_code(input logic sel, input logic [1:0] phase);
        logic [1:0] code;
        case ({sel, phase})
            3'b0_00: code = LO_POS;
            3'b0_01: code = LO_ZERO;
            3'b0_10: code = LO_NEG;
            3'b0_11: code = LO_ZERO;
            3'b1_00: code = LO_ZERO;
            3'b1_01: code = LO_POS;
            3'b1_10: code = LO_ZERO;
            3'b1_11: code = LO_NEG;
            default: code = LO_ZERO;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            state,  state_nxt;
    logic              sel_l,  sel_nxt;   // phase_sel latched at start
    logic [DIV_W-1:0]  div_l,  div_nxt;   // rate_div latched at start
    logic [1:0]        p,      p_nxt;     // LO phase index, 0..3
    logic [DIV_W-1:0]  c,      c_nxt;     // samples emitted at the current phase

    // Stream handshake and per-sample values
    logic              accept;
    logic [1:0]        code_cur;          // code for a sample accepted this cycle
    logic              div_wrap;          // this accept ends the current phase

    // The register may take a new sample when it is empty or is being
    // drained this same cycle. That keeps throughput at one sample per cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign div_wrap = (c == div_l);

    // Code that goes with a sample accepted now. IDLE always emits zero, and
    // that includes the cycle in which en starts a run.
    always_comb begin
        code_cur = LO_ZERO;
        if (state != ST_IDLE) begin
            code_cur = seq_code(sel_l, p);
        end
    end

    // Next-state, latch and divider logic.
    // NOTE: every variable gets its default before the case statement. Then
    // each path through the block assigns it, and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_l;
        div_nxt   = div_l;
        p_nxt     = p;
        c_nxt     = c;

        case (state)
            ST_IDLE: begin
                // The phase is parked at zero while idle.
                p_nxt = 2'd0;
                c_nxt = '0;
                if (en) begin
                    state_nxt = ST_RUN;
                    sel_nxt   = phase_sel;
                    div_nxt   = rate_div;
                end
            end

            ST_RUN: begin
                if (accept) begin
                    if (div_wrap) begin
                        c_nxt = '0;
                        p_nxt = p + 2'd1;
                    end else begin
                        c_nxt = c + 1'b1;
                    end
                end
                if (!en) begin
                    state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (en) begin
                    // Resume with p and c untouched so the pattern continues
                    // without a glitch. This path wins even if this accept
                    // carries a zero code.
                    state_nxt = ST_RUN;
                    if (accept) begin
                        if (div_wrap) begin
                            c_nxt = '0;
                            p_nxt = p + 2'd1;
                        end else begin
                            c_nxt = c + 1'b1;
                        end
                    end
                end else if (accept) begin
                    if (code_cur == LO_ZERO) begin
                        // The lobe is complete, so it is safe to stop here.
                        state_nxt = ST_IDLE;
                        p_nxt     = 2'd0;
                        c_nxt     = '0;
                    end else if (div_wrap) begin
                        c_nxt = '0;
                        p_nxt = p + 2'd1;
                    end else begin
                        c_nxt = c + 1'b1;
                    end
                end
                // With no accepts the block waits here indefinitely.
            end

            default: begin
                state_nxt = ST_IDLE;
                p_nxt     = 2'd0;
                c_nxt     = '0;
            end
        endcase
    end

    // State, latched configuration, phase/divider counters and busy flag.
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel_l <= 1'b0;
            div_l <= '0;
            p     <= 2'd0;
            c     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            sel_l <= sel_nxt;
            div_l <= div_nxt;
            p     <= p_nxt;
            c     <= c_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Output register stage: load on accept, empty when drained with
    // nothing new arriving, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            interp_o  <= '0;
            lo        <= LO_ZERO;
        end else if (accept) begin
            out_valid <= 1'b1;
            interp_o  <= interp_i;
            lo        <= code_cur;
        end else if (out_ready) begin
            // No accept while out_ready=1 means in_valid was low.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mixer_lo_ctrl.sv
// Testbench for mixer_lo_ctrl. The main checks come from a table of
// per-cycle vectors. Hand-written sequences follow for reset mid-run,
// graceful stop, and resume from DRAIN.
`timescale 1ns/1ps

module tb_mixer_lo_ctrl;

    localparam int DIV_W  = 4;
    localparam int DATA_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              phase_sel;
    logic [DIV_W-1:0]  rate_div;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] interp_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] interp_o;
    logic [1:0]        lo;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mixer_lo_ctrl #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .phase_sel (phase_sel),
        .rate_div  (rate_div),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .interp_i  (interp_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .interp_o  (interp_o),
        .lo        (lo),
        .busy      (busy)
    );

    // One cycle of stimulus, plus the outputs expected after its clock edge.
    // in_ready is combinational, so it is checked before the edge.
    typedef struct {
        logic              rst;
        logic              en;
        logic              sel;
        logic [DIV_W-1:0]  div;
        logic              iv;
        logic [DATA_W-1:0] din;
        logic              ordy;
        logic              chk_ir;
        logic              exp_ir;
        logic              exp_ov;
        logic [DATA_W-1:0] exp_dout;
        logic [1:0]        exp_lo;
        logic              exp_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic s, input int d,
                                input logic v, input int di, input logic o,
                                input logic cir, input logic ir, input logic ov,
                                input int dout, input int l, input logic b);
        vec_t t;
        t.rst = r;  t.en = e;  t.sel = s;  t.div = DIV_W'(d);
        t.iv = v;   t.din = DATA_W'(di);   t.ordy = o;
        t.chk_ir = cir;  t.exp_ir = ir;    t.exp_ov = ov;
        t.exp_dout = DATA_W'(dout);  t.exp_lo = 2'(l);  t.exp_busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        rst       = v.rst;
        en        = v.en;
        phase_sel = v.sel;
        rate_div  = v.div;
        in_valid  = v.iv;
        interp_i  = v.din;
        out_ready = v.ordy;
        #1;
        if (v.chk_ir) check({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        check({tag, " interp_o"},  32'(interp_o),  32'(v.exp_dout));
        check({tag, " lo"},        32'(lo),        32'(v.exp_lo));
        check({tag, " busy"},      32'(busy),      32'(v.exp_busy));
    endtask

    vec_t tbl[$];
    int   i_codes[4] = '{1, 0, 2, 0};
    int   q_codes[4] = '{0, 1, 0, 2};

    initial begin
        rst = 1'b1; en = 1'b0; phase_sel = 1'b0; rate_div = '0;
        in_valid = 1'b0; interp_i = '0; out_ready = 1'b0;

        // Fields: rst en sel div iv din ordy | chk_ir ir ov dout lo busy
        // Reset, then idle streaming: codes are zero and busy stays low.
        tbl.push_back(mk(1,0,0,0, 0,0,0,   0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,   1,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,5,1,   1,1, 1,5,0,0));
        tbl.push_back(mk(0,0,0,0, 1,6,1,   1,1, 1,6,0,0));
        tbl.push_back(mk(0,0,0,0, 1,7,1,   1,1, 1,7,0,0));
        // I sequence, rate_div=0. The sample accepted on the start cycle
        // still carries a zero code.
        tbl.push_back(mk(0,1,0,0, 1,99,1,  1,1, 1,99,0,1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,1,0,0, 1,100+i,1, 1,1, 1,100+i,i_codes[i%4],1));
        // Drop en at p0 -> DRAIN; emit +1, then 0, then back to IDLE.
        tbl.push_back(mk(0,0,0,0, 0,0,1,   1,1, 0,107,0,1));
        tbl.push_back(mk(0,0,0,0, 1,108,1, 1,1, 1,108,1,1));
        tbl.push_back(mk(0,0,0,0, 1,109,1, 1,1, 1,109,0,0));
        // Q sequence, rate_div=2. Halfway through, sel/div change on the
        // inputs; the run must ignore it.
        tbl.push_back(mk(0,1,1,2, 0,0,1,   1,1, 0,109,0,1));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0,1,(i<6),(i<6)?2:0, 1,200+i,1, 1,1, 1,200+i,q_codes[i/3],1));
        // Backpressure at p0 with c=1: outputs hold while out_ready=0.
        tbl.push_back(mk(0,1,0,0, 1,212,1, 1,1, 1,212,0,1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,0,0, 1,213+k,0, 1,0, 1,212,0,1));
        tbl.push_back(mk(0,1,0,0, 1,216,1, 1,1, 1,216,0,1));
        tbl.push_back(mk(0,1,0,0, 1,217,1, 1,1, 1,217,0,1));
        tbl.push_back(mk(0,1,0,0, 1,218,1, 1,1, 1,218,1,1));
        tbl.push_back(mk(0,1,0,0, 1,219,1, 1,1, 1,219,1,1));
        tbl.push_back(mk(0,1,0,0, 1,220,1, 1,1, 1,220,1,1));

        foreach (tbl[n]) step($sformatf("row%0d", n), tbl[n]);

        // Reset mid-run: out_valid=1 and p=2. Reset beats en and in_valid.
        step("rst_mid",   mk(1,1,0,0, 1,300,1, 1,1, 0,0,0,0));
        step("restart",   mk(0,1,0,0, 0,0,1,   1,1, 0,0,0,1));
        step("restart_p0",mk(0,1,0,0, 1,301,1, 1,1, 1,301,1,1));

        // Graceful stop: en drops while the next code is -1.
        step("stop_p1",   mk(0,1,0,0, 1,302,1, 1,1, 1,302,0,1));
        step("stop_neg",  mk(0,0,0,0, 1,303,1, 1,1, 1,303,2,1));
        step("stop_zero", mk(0,0,0,0, 1,304,1, 1,1, 1,304,0,0));

        // Resume from DRAIN. With no accepts it stays in DRAIN. Then en and
        // a zero-code accept arrive together, and en wins.
        step("re_start",  mk(0,1,0,0, 0,0,1,   1,1, 0,304,0,1));
        step("re_p0",     mk(0,1,0,0, 1,305,1, 1,1, 1,305,1,1));
        step("re_p1",     mk(0,1,0,0, 1,306,1, 1,1, 1,306,0,1));
        step("re_drop",   mk(0,0,0,0, 1,307,1, 1,1, 1,307,2,1));
        step("drain_w0",  mk(0,0,0,0, 0,0,1,   1,1, 0,307,2,1));
        step("drain_w1",  mk(0,0,0,0, 0,0,1,   1,1, 0,307,2,1));
        step("resume_p3", mk(0,1,0,0, 1,308,1, 1,1, 1,308,0,1));
        step("resume_p0", mk(0,1,0,0, 1,309,1, 1,1, 1,309,1,1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
